// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline types: register index sizing and the per-slot
// destination record carried alongside the EXE/MEM/WB pipeline registers.
package arm_pipe_pkg;

  parameter int REG_W    = 4;
  parameter int NUM_REGS = 2 ** REG_W;

  typedef struct packed {
    logic             wb_en;
    logic [REG_W-1:0] dest;
  } dest_slot_t;

  // An empty slot: no write-back and a zeroed destination
  localparam dest_slot_t DEST_BUBBLE = '0;

endpackage

// File: rtl/pend_counter_bank.sv
// Bank of NUM_REGS 2-bit up/down counters, one per architectural register.
// Each counter moves by +1 on inc, -1 on dec and holds when both or neither
// are set, so a register entering EXE while it retires from WB nets to zero.
module pend_counter_bank
  import arm_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REGS-1:0]   inc,
  input  logic [NUM_REGS-1:0]   dec,
  output logic [NUM_REGS*2-1:0] cnt
);

  // Per-register pending-write counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc[r] && !dec[r])
          cnt[2*r +: 2] <= cnt[2*r +: 2] + 2'd1;
        else if (dec[r] && !inc[r])
          cnt[2*r +: 2] <= cnt[2*r +: 2] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/dest_tracker.sv
// Destination tracker for the EXE, MEM and WB slots of the 5-stage pipeline.
// Shifts {wb_en, dest} records in lockstep with the pipeline registers,
// keeps a pending-write count per register and counts hazard bubbles.
module dest_tracker
  import arm_pipe_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_wb_en,
  input  logic [REG_W-1:0]      id_dest,
  input  logic                  hazard,
  input  logic                  branch_taken,
  input  logic                  freeze,
  output logic [REG_W-1:0]      EXE_Dest,
  output logic                  EXE_WB_EN,
  output logic [REG_W-1:0]      Mem_Dest,
  output logic                  MEM_WB_EN,
  output logic [REG_W-1:0]      WB_Dest,
  output logic                  WB_WB_EN,
  output logic [NUM_REGS*2-1:0] pend_cnt,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic [CNT_W-1:0]      bubble_cnt
);

  dest_slot_t          exe_slot_p0;
  dest_slot_t          mem_slot_p1;
  dest_slot_t          wb_slot_p2;
  dest_slot_t          id_slot;
  logic                accept;
  logic                count_bubble;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Admission decision and pending-count increment/decrement vectors
  always_comb begin
    accept       = !freeze && id_valid && !hazard && !branch_taken;
    count_bubble = !freeze && hazard && id_valid;
    id_slot      = DEST_BUBBLE;
    id_slot.wb_en = id_wb_en;
    id_slot.dest  = id_wb_en ? id_dest : '0;
    inc_vec      = '0;
    dec_vec      = '0;
    if (accept && id_wb_en)
      inc_vec[id_dest] = 1'b1;
    // WB is overwritten on every unfrozen edge, retiring its write
    if (!freeze && wb_slot_p2.wb_en)
      dec_vec[wb_slot_p2.dest] = 1'b1;
  end

  // ---- ID -> EXE (p0) -> MEM (p1) -> WB (p2) slot shift chain ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_slot_p0 <= DEST_BUBBLE;
      mem_slot_p1 <= DEST_BUBBLE;
      wb_slot_p2  <= DEST_BUBBLE;
    end else if (!freeze) begin
      wb_slot_p2  <= mem_slot_p1;
      mem_slot_p1 <= exe_slot_p0;
      exe_slot_p0 <= accept ? id_slot : DEST_BUBBLE;
    end
  end

  // Saturating count of hazard-induced bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubble_cnt <= '0;
    else if (count_bubble)
      bubble_cnt <= sat_inc(bubble_cnt);
  end

  pend_counter_bank u_pend (
    .clk (clk),
    .rst (rst),
    .inc (inc_vec),
    .dec (dec_vec),
    .cnt (pend_cnt)
  );

  // Busy whenever any slot holds a pending write to the register
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      busy_mask[r] = |pend_cnt[2*r +: 2];
  end

  assign EXE_Dest  = exe_slot_p0.dest;
  assign EXE_WB_EN = exe_slot_p0.wb_en;
  assign Mem_Dest  = mem_slot_p1.dest;
  assign MEM_WB_EN = mem_slot_p1.wb_en;
  assign WB_Dest   = wb_slot_p2.dest;
  assign WB_WB_EN  = wb_slot_p2.wb_en;

endmodule

// File: tb/tb_dest_tracker.sv
// Bench for dest_tracker: directed vector table, reset/saturation sequences
// and a random run against a small slot model.
module tb_dest_tracker;

  logic        clk;
  logic        rst;
  logic        id_valid, id_wb_en, hazard, branch_taken, freeze;
  logic [3:0]  id_dest;
  logic [3:0]  EXE_Dest, Mem_Dest, WB_Dest;
  logic        EXE_WB_EN, MEM_WB_EN, WB_WB_EN;
  logic [31:0] pend_cnt;
  logic [15:0] busy_mask;
  logic [3:0]  bubble_cnt;

  int tests;
  int failed;

  dest_tracker #(.CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_wb_en     (id_wb_en),
    .id_dest      (id_dest),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .freeze       (freeze),
    .EXE_Dest     (EXE_Dest),
    .EXE_WB_EN    (EXE_WB_EN),
    .Mem_Dest     (Mem_Dest),
    .MEM_WB_EN    (MEM_WB_EN),
    .WB_Dest      (WB_Dest),
    .WB_WB_EN     (WB_WB_EN),
    .pend_cnt     (pend_cnt),
    .busy_mask    (busy_mask),
    .bubble_cnt   (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       w;
    logic [3:0] d;
    logic       hz;
    logic       br;
    logic       fz;
    logic [4:0] exe;
    logic [4:0] mem;
    logic [4:0] wb;
    logic [3:0] bub;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] recount(input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] c);
    logic [31:0] p;
    p = '0;
    for (int r = 0; r < 16; r++) begin
      logic [1:0] n;
      n = 2'd0;
      if (a[4] && a[3:0] == r[3:0]) n = n + 2'd1;
      if (b[4] && b[3:0] == r[3:0]) n = n + 2'd1;
      if (c[4] && c[3:0] == r[3:0]) n = n + 2'd1;
      p[2*r +: 2] = n;
    end
    return p;
  endfunction

  function automatic logic [15:0] busy_of(input logic [31:0] p);
    logic [15:0] b;
    for (int r = 0; r < 16; r++) b[r] = |p[2*r +: 2];
    return b;
  endfunction

  task automatic drive(input logic v, input logic w, input logic [3:0] d,
                       input logic hz, input logic br, input logic fz);
    id_valid = v; id_wb_en = w; id_dest = d;
    hazard = hz; branch_taken = br; freeze = fz;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [4:0] exe, input logic [4:0] mem,
                         input logic [4:0] wb, input logic [3:0] bub);
    logic [31:0] p;
    p = recount(exe, mem, wb);
    chk({tag, ".exe"},  {27'd0, EXE_WB_EN, EXE_Dest}, {27'd0, exe});
    chk({tag, ".mem"},  {27'd0, MEM_WB_EN, Mem_Dest}, {27'd0, mem});
    chk({tag, ".wb"},   {27'd0, WB_WB_EN, WB_Dest},   {27'd0, wb});
    chk({tag, ".bub"},  {28'd0, bubble_cnt},          {28'd0, bub});
    chk({tag, ".pend"}, pend_cnt,                     p);
    chk({tag, ".busy"}, {16'd0, busy_mask},           {16'd0, busy_of(p)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 4'd0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] m_exe, m_mem, m_wb;
    logic [3:0] m_bub;
    tests = 0;
    failed = 0;

    // Power-on reset
    do_reset();
    chk_all("reset", 5'h00, 5'h00, 5'h00, 4'h0);

    // Directed vector table
    vq.push_back('{1,1,4'd3,0,0,0, 5'h13,5'h00,5'h00,4'd0});
    vq.push_back('{0,0,4'd0,0,0,0, 5'h00,5'h13,5'h00,4'd0});
    vq.push_back('{0,0,4'd0,0,0,0, 5'h00,5'h00,5'h13,4'd0});
    vq.push_back('{0,0,4'd0,0,0,0, 5'h00,5'h00,5'h00,4'd0});
    vq.push_back('{1,1,4'd5,0,0,0, 5'h15,5'h00,5'h00,4'd0});
    vq.push_back('{1,1,4'd5,0,0,0, 5'h15,5'h15,5'h00,4'd0});
    vq.push_back('{1,1,4'd5,0,0,0, 5'h15,5'h15,5'h15,4'd0});
    vq.push_back('{1,1,4'd5,0,0,0, 5'h15,5'h15,5'h15,4'd0});
    vq.push_back('{1,1,4'd7,1,0,0, 5'h00,5'h15,5'h15,4'd1});
    vq.push_back('{1,1,4'd7,0,1,0, 5'h00,5'h00,5'h15,4'd1});
    vq.push_back('{1,1,4'd7,1,1,0, 5'h00,5'h00,5'h00,4'd2});
    vq.push_back('{1,0,4'd9,0,0,0, 5'h00,5'h00,5'h00,4'd2});
    vq.push_back('{1,1,4'd2,0,0,0, 5'h12,5'h00,5'h00,4'd2});
    for (int k = 0; k < 4; k++)
      vq.push_back('{1,1,4'd4,1,0,1, 5'h12,5'h00,5'h00,4'd2});
    vq.push_back('{1,1,4'd6,0,0,0, 5'h16,5'h12,5'h00,4'd2});
    vq.push_back('{0,0,4'd0,0,0,0, 5'h00,5'h16,5'h12,4'd2});
    vq.push_back('{0,0,4'd0,0,0,0, 5'h00,5'h00,5'h16,4'd2});
    vq.push_back('{0,0,4'd0,0,0,0, 5'h00,5'h00,5'h00,4'd2});

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].v, vq[i].w, vq[i].d, vq[i].hz, vq[i].br, vq[i].fz);
      step();
      chk_all($sformatf("vec%0d", i), vq[i].exe, vq[i].mem, vq[i].wb, vq[i].bub);
    end

    // Asynchronous reset mid-stream with all slots full
    drive(1, 1, 4'd8, 0, 0, 0);
    step();
    drive(1, 1, 4'd9, 0, 0, 0);
    step();
    drive(1, 1, 4'd10, 1, 0, 0);
    step();
    chk_all("full", 5'h00, 5'h19, 5'h18, 4'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 5'h00, 5'h00, 5'h00, 4'd0);
    drive(1, 1, 4'd1, 0, 0, 0);
    step();
    chk_all("rst_hold", 5'h00, 5'h00, 5'h00, 4'd0);
    rst = 1'b0;
    step();
    chk_all("rst_release", 5'h11, 5'h00, 5'h00, 4'd0);

    // Bubble counter saturation
    do_reset();
    drive(1, 1, 4'd7, 1, 0, 0);
    for (int k = 0; k < 14; k++) step();
    chk_all("sat14", 5'h00, 5'h00, 5'h00, 4'hE);
    step();
    chk_all("sat15", 5'h00, 5'h00, 5'h00, 4'hF);
    step();
    chk_all("sat16", 5'h00, 5'h00, 5'h00, 4'hF);
    step();
    chk_all("sat17", 5'h00, 5'h00, 5'h00, 4'hF);

    // Random run against the slot model
    do_reset();
    m_exe = '0; m_mem = '0; m_wb = '0; m_bub = '0;
    for (int k = 0; k < 300; k++) begin
      logic v, w, hz, br, fz;
      logic [3:0] d;
      v  = 1'($urandom_range(0, 3) != 0);
      w  = 1'($urandom_range(0, 3) != 0);
      d  = 4'($urandom_range(0, 3));
      hz = 1'($urandom_range(0, 4) == 0);
      br = 1'($urandom_range(0, 6) == 0);
      fz = 1'($urandom_range(0, 4) == 0);
      drive(v, w, d, hz, br, fz);
      if (!fz) begin
        if (hz && v && m_bub != 4'hF) m_bub = m_bub + 4'd1;
        m_wb  = m_mem;
        m_mem = m_exe;
        m_exe = (v && !hz && !br && w) ? {1'b1, d} : 5'h00;
      end
      step();
      chk_all($sformatf("rnd%0d", k), m_exe, m_mem, m_wb, m_bub);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
